tych_egr_c2m_avl: RTL and testbench
===================================

Name: tych_egr_c2m_avl

Overview:
- Egress counterpart of the ingress MAC-to-core adapter. Converts the core AVL stream (core_avl_t) into the MAC TX Avalon-ST stream (mac_avltx_t).
- Adds ready/valid backpressure with a 2-entry skid buffer and enforces sop/eop framing toward the MAC.
- Counts transmitted and dropped frames and reports the debug ID of the last frame sent.
- Sits between the egress scheduler and the MAC TX port.

Parameters:
- CNT_W, 16, width of the tx_frm_cnt and drop_frm_cnt statistics counters.

Ports:
- clk  input  1  core clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- core_avl  input  core_avl_t  core stream (valid, data, sop, eop, empty, error, frm_dbg_id).
- core_ready  output  1  block accepts the core_avl beat this cycle.
- mac_tx  output  mac_avltx_t  MAC TX stream (valid, data, sop, eop, empty, error).
- mac_tx_ready  input  1  MAC accepts the mac_tx beat this cycle.
- tx_frm_cnt  output  CNT_W  frames completed on MAC side (eop accepted).
- drop_frm_cnt  output  CNT_W  malformed input frames dropped or truncated.
- last_dbg_id  output  12  frm_dbg_id of the last frame whose eop was accepted by the MAC.

Behaviour:
- Reset values:
  - mac_tx all fields 0; core_ready 0 during rst, 1 in the first cycle after reset.
  - Counters 0; last_dbg_id 12'h000; FSM in IDLE; skid buffer empty.
- Handshakes:
  - Input beat accepted when core_avl.valid & core_ready.
  - Output beat transferred when mac_tx.valid & mac_tx_ready.
  - mac_tx fields hold stable while valid & !ready; valid never drops without a transfer.
- Buffering:
  - Output is a register plus one skid entry.
  - core_ready = skid entry empty, registered, so there is no combinational path from mac_tx_ready.
  - Latency is 1 cycle: an accepted beat appears on mac_tx the next cycle when the output register is free.
  - Full throughput is 1 beat/clk while mac_tx_ready=1.
  - On a stall the second beat lands in the skid entry. When the output transfers, the skid entry moves to the output register and the skid empties.
- Field mapping:
  - data, empty and sop pass through unchanged.
  - error is sampled on the eop beat only; error on non-eop beats is latched and ORed into that frame's eop error.
  - frm_dbg_id is captured at sop into the beat metadata and is not sent to the MAC.
- Framing FSM, evaluated on accepted input beats only:
  - IDLE:
    - sop&eop: forward the beat, stay IDLE.
    - sop&!eop: forward, go to INFRM.
    - !sop: drop the beat (no MAC output), drop_frm_cnt+1, go to DROP unless eop is set.
  - INFRM:
    - !sop&eop: forward, go to IDLE.
    - !sop&!eop: forward, stay.
    - sop (sop in the middle of a frame): forward the beat with sop=0, eop=1, error=1 to terminate the open frame; drop_frm_cnt+1; go to DROP if !eop, else IDLE.
  - DROP:
    - Discard all beats. eop goes to IDLE.
    - A sop while in DROP is treated as IDLE-sop, forwarded normally.
- Counters:
  - tx_frm_cnt increments on MAC-side accepted eop, including truncated error frames. It wraps at 2^CNT_W.
  - drop_frm_cnt wraps at 2^CNT_W.
  - Simultaneous increments of different counters are independent.
- last_dbg_id updates on MAC-side accepted eop, using the dbg_id held with that frame.
- Reset mid-frame:
  - Buffered beats are discarded, mac_tx.valid goes to 0 the next cycle, and the FSM returns to IDLE. A partial frame at the MAC is the MAC's concern.
- Dropped beats still assert core_ready; they consume no buffer entry.

Decomposition:
- mac_avl_structures package: mac_avltx_t (valid, data, sop, eop, empty, error) and MAC_DATA_W / MAC_EMPTY_W constants shared with mac_avlrx_t.
- core_structures package: core_avl_t (already present) and DBG_ID_W = 12.
- One sub-module: tych_avl_skid, a generic 2-entry registered skid buffer parameterised by payload width and reusable on ingress.
- The framing FSM and counters stay in the top module.

Test Plan:
- Stream three 4-beat frames (dbg_id 1,2,3), mac_tx_ready=1 → MAC sees 12 beats, each 1 cycle after input; tx_frm_cnt=3; last_dbg_id=3; no bubbles.
- Same stream with mac_tx_ready toggling 1,0,0,1 repeating → no beat lost or duplicated; mac_tx stable during stalls; core_ready drops only when the skid is full.
- Orphan 2-beat burst (no sop) then a valid 1-beat sop&eop frame → drop_frm_cnt=1; MAC sees only the single-beat frame; tx_frm_cnt=1.
- sop at beat 3 of an open frame, new frame 3 beats long → MAC beat 3 has eop=1, error=1; next 2 beats discarded; drop_frm_cnt=1; tx_frm_cnt=1.
- error=1 on beat 2 of a 4-beat frame → MAC error=0 on beats 1–3 and error=1 on eop beat 4.
- Assert rst for 1 cycle during beat 2 of 4 with the MAC stalled → next cycle mac_tx.valid=0 and counters=0; the following sop frame passes cleanly.
- Force tx_frm_cnt to 16'hFFFF, send one frame → counter wraps to 0.

Source files
------------

// File: rtl/tych_egr_c2m_avl_pkg.sv
// Shared stream types for the egress core-to-MAC Avalon adapter.
// Holds MAC TX / core AVL beat layouts, the internal beat and the framing states.
package tych_egr_c2m_avl_pkg;

    localparam int MAC_DATA_W  = 64;
    localparam int MAC_EMPTY_W = 3;
    localparam int DBG_ID_W    = 12;

    typedef struct packed {
        logic                   valid;
        logic [MAC_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [MAC_EMPTY_W-1:0] empty;
        logic                   error;
    } mac_avltx_t;

    typedef struct packed {
        logic                   valid;
        logic [MAC_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [MAC_EMPTY_W-1:0] empty;
        logic                   error;
        logic [DBG_ID_W-1:0]    frm_dbg_id;
    } core_avl_t;

    // Beat as held in the output buffer; dbg_id travels with it but never reaches the MAC.
    typedef struct packed {
        logic [MAC_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [MAC_EMPTY_W-1:0] empty;
        logic                   error;
        logic [DBG_ID_W-1:0]    dbg_id;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INFRM,
        ST_DROP
    } frm_st_t;

endpackage

// File: rtl/tych_avl_skid.sv
// Generic 2-entry skid buffer: output register plus one skid entry.
// in_ready is registered so upstream never sees a path from out_ready.
module tych_avl_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         skid_valid;
    logic         skid_nxt;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         out_free;

    assign in_fire  = in_valid & in_ready;
    assign out_free = !out_valid | out_ready;

    always_comb begin
        skid_nxt = skid_valid;
        if (out_free) begin
            skid_nxt = 1'b0;
        end else if (in_fire) begin
            skid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            skid_valid <= skid_nxt;
            in_ready   <= !skid_nxt;
            if (out_free) begin
                // in_ready is low whenever the skid holds a beat, so no collision
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                end else begin
                    out_valid <= in_fire;
                    if (in_fire) begin
                        out_data <= in_data;
                    end
                end
            end else if (in_fire) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/tych_egr_c2m_avl.sv
// Egress adapter: core AVL stream to MAC TX Avalon-ST with framing repair,
// skid-buffered backpressure and frame statistics.
module tych_egr_c2m_avl
    import tych_egr_c2m_avl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  core_avl_t           core_avl,
    output logic                core_ready,
    output mac_avltx_t          mac_tx,
    input  logic                mac_tx_ready,
    output logic [CNT_W-1:0]    tx_frm_cnt,
    output logic [CNT_W-1:0]    drop_frm_cnt,
    output logic [DBG_ID_W-1:0] last_dbg_id
);

    frm_st_t             st;
    frm_st_t             st_nxt;
    logic                err_q;
    logic                err_nxt;
    logic [DBG_ID_W-1:0] dbg_q;
    logic [DBG_ID_W-1:0] dbg_nxt;
    logic                acc;
    logic                fwd;
    logic                drop_inc;
    logic                tx_eop;
    beat_t               beat;
    beat_t               out_beat;
    logic [BEAT_W-1:0]   out_raw;
    logic                out_valid;

    assign acc = core_avl.valid & core_ready;

    always_comb begin
        st_nxt      = st;
        err_nxt     = err_q;
        dbg_nxt     = dbg_q;
        fwd         = 1'b0;
        drop_inc    = 1'b0;
        beat.data   = core_avl.data;
        beat.sop    = core_avl.sop;
        beat.eop    = core_avl.eop;
        beat.empty  = core_avl.empty;
        beat.error  = 1'b0;
        beat.dbg_id = core_avl.sop ? core_avl.frm_dbg_id : dbg_q;
        if (acc) begin
            unique case (st)
                ST_IDLE, ST_DROP: begin
                    if (core_avl.sop) begin
                        fwd        = 1'b1;
                        beat.error = core_avl.eop & core_avl.error;
                        dbg_nxt    = core_avl.frm_dbg_id;
                        err_nxt    = !core_avl.eop & core_avl.error;
                        st_nxt     = core_avl.eop ? ST_IDLE : ST_INFRM;
                    end else if (st == ST_IDLE) begin
                        drop_inc = 1'b1;
                        st_nxt   = core_avl.eop ? ST_IDLE : ST_DROP;
                    end else if (core_avl.eop) begin
                        st_nxt = ST_IDLE;
                    end
                end
                ST_INFRM: begin
                    fwd = 1'b1;
                    if (!core_avl.sop) begin
                        beat.error = core_avl.eop & (core_avl.error | err_q);
                        err_nxt    = !core_avl.eop & (core_avl.error | err_q);
                        st_nxt     = core_avl.eop ? ST_IDLE : ST_INFRM;
                    end else begin
                        // Early sop closes the open frame as an errored eop
                        beat.sop    = 1'b0;
                        beat.eop    = 1'b1;
                        beat.error  = 1'b1;
                        beat.dbg_id = dbg_q;
                        drop_inc    = 1'b1;
                        err_nxt     = 1'b0;
                        st_nxt      = core_avl.eop ? ST_IDLE : ST_DROP;
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    tych_avl_skid #(
        .W (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fwd),
        .in_data   (beat),
        .in_ready  (core_ready),
        .out_valid (out_valid),
        .out_data  (out_raw),
        .out_ready (mac_tx_ready)
    );

    assign out_beat     = beat_t'(out_raw);
    assign mac_tx.valid = out_valid;
    assign mac_tx.data  = out_beat.data;
    assign mac_tx.sop   = out_beat.sop;
    assign mac_tx.eop   = out_beat.eop;
    assign mac_tx.empty = out_beat.empty;
    assign mac_tx.error = out_beat.error;

    assign tx_eop = out_valid & mac_tx_ready & out_beat.eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_IDLE;
            err_q        <= 1'b0;
            dbg_q        <= '0;
            tx_frm_cnt   <= '0;
            drop_frm_cnt <= '0;
            last_dbg_id  <= '0;
        end else begin
            st    <= st_nxt;
            err_q <= err_nxt;
            dbg_q <= dbg_nxt;
            if (drop_inc) begin
                drop_frm_cnt <= drop_frm_cnt + CNT_W'(1);
            end
            if (tx_eop) begin
                tx_frm_cnt  <= tx_frm_cnt + CNT_W'(1);
                last_dbg_id <= out_beat.dbg_id;
            end
        end
    end

endmodule

// File: tb/tb_tych_egr_c2m_avl.sv
// Scoreboard bench for tych_egr_c2m_avl: directed frames, stalls,
// framing repair, mid-frame reset and counter wrap (4-bit counters).
module tb_tych_egr_c2m_avl;
    import tych_egr_c2m_avl_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        error;
    } exp_t;

    typedef struct {
        exp_t b;
        int   at;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    core_avl_t     core_avl = '0;
    logic          core_ready;
    mac_avltx_t    mac_tx;
    logic          mac_tx_ready = 1'b1;
    logic [CW-1:0] tx_frm_cnt;
    logic [CW-1:0] drop_frm_cnt;
    logic [11:0]   last_dbg_id;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_on = 0;
    bit   tog_en = 0;
    ent_t q[$];

    tych_egr_c2m_avl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_avl     (core_avl),
        .core_ready   (core_ready),
        .mac_tx       (mac_tx),
        .mac_tx_ready (mac_tx_ready),
        .tx_frm_cnt   (tx_frm_cnt),
        .drop_frm_cnt (drop_frm_cnt),
        .last_dbg_id  (last_dbg_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // MAC ready pattern 1,0,0,1 while enabled
    initial begin
        int pi = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                mac_tx_ready = pat[pi];
                pi = (pi + 1) % 4;
            end
        end
    end

    // Monitor: pops the scoreboard on every MAC transfer, checks stall stability
    initial begin
        bit         stall_prev = 0;
        mac_avltx_t prev = '0;
        exp_t       a;
        ent_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_hold", 64'(mac_tx != prev), 64'd0);
                end
                if (mac_tx.valid && mac_tx_ready) begin
                    a.data  = mac_tx.data;
                    a.sop   = mac_tx.sop;
                    a.eop   = mac_tx.eop;
                    a.empty = mac_tx.empty;
                    a.error = mac_tx.error;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat got data %h nothing expected", a.data);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", a.data, e.b.data);
                        chk("beat_ctl", 64'({a.sop, a.eop, a.empty, a.error}),
                            64'({e.b.sop, e.b.eop, e.b.empty, e.b.error}));
                        if (e.at >= 0) begin
                            chk("beat_latency", 64'(cyc), 64'(e.at));
                        end
                    end
                end
                stall_prev = mac_tx.valid && !mac_tx_ready;
                prev = mac_tx;
            end
        end
    end

    function automatic core_avl_t mk(input logic s, input logic e, input logic er,
                                     input logic [11:0] id, input logic [63:0] d,
                                     input logic [2:0] emp);
        core_avl_t c;
        c.valid      = 1'b1;
        c.data       = d;
        c.sop        = s;
        c.eop        = e;
        c.empty      = emp;
        c.error      = er;
        c.frm_dbg_id = id;
        return c;
    endfunction

    function automatic exp_t xp(input logic [63:0] d, input logic s, input logic e,
                                input logic [2:0] emp, input logic er);
        exp_t x;
        x.data  = d;
        x.sop   = s;
        x.eop   = e;
        x.empty = emp;
        x.error = er;
        return x;
    endfunction

    // Call just after a posedge; returns #1 after the accepting posedge
    task automatic send(input core_avl_t b, input bit fwd, input exp_t x);
        int n = 0;
        bit r = 0;
        ent_t e;
        core_avl = b;
        do begin
            @(negedge clk);
            r = core_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 50);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got core_ready 0 expected 1");
        end else if (fwd) begin
            e.b  = x;
            e.at = lat_on ? cyc + 1 : -1;
            q.push_back(e);
        end
        #1;
        core_avl.valid = 1'b0;
    endtask

    task automatic frame(input logic [11:0] id, input int n, input int errb);
        for (int b = 1; b <= n; b++) begin
            logic [63:0] d;
            logic [2:0]  emp;
            d   = 64'(id) * 64'h100 + 64'(b);
            emp = (b == n) ? 3'd5 : 3'd0;
            send(mk(b == 1, b == n, b == errb, id, d, emp), 1'b1,
                 xp(d, b == 1, b == n, emp, (b == n) && (errb != 0)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || mac_tx.valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(q.size()) + 64'(mac_tx.valid), 64'd0);
        @(negedge clk);
    endtask

    task automatic cnts(input string nm, input logic [CW-1:0] tx,
                        input logic [CW-1:0] dr, input logic [11:0] id);
        chk({nm, "_tx"}, 64'(tx_frm_cnt), 64'(tx));
        chk({nm, "_drop"}, 64'(drop_frm_cnt), 64'(dr));
        chk({nm, "_dbg"}, 64'(last_dbg_id), 64'(id));
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_core_ready", 64'(core_ready), 64'd0);
        chk("rst_mac_tx", 64'(mac_tx != '0), 64'd0);
        sync();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'(core_ready), 64'd1);
        cnts("reset", 4'd0, 4'd0, 12'h000);
        sync();

        // Full rate, 1-cycle latency
        lat_on = 1;
        frame(12'd1, 4, 0);
        frame(12'd2, 4, 0);
        frame(12'd3, 4, 0);
        lat_on = 0;
        drain();
        cnts("stream", 4'd3, 4'd0, 12'd3);
        sync();

        // Backpressure 1,0,0,1
        tog_en = 1;
        frame(12'd1, 4, 0);
        frame(12'd2, 4, 0);
        frame(12'd3, 4, 0);
        drain();
        tog_en = 0;
        mac_tx_ready = 1'b1;
        cnts("stall", 4'd6, 4'd0, 12'd3);
        sync();

        // Orphan burst then a single-beat frame
        send(mk(1'b0, 1'b0, 1'b0, 12'd0, 64'hA1, 3'd0), 1'b0, '0);
        send(mk(1'b0, 1'b1, 1'b0, 12'd0, 64'hA2, 3'd1), 1'b0, '0);
        frame(12'd7, 1, 0);
        drain();
        cnts("orphan", 4'd7, 4'd1, 12'd7);
        sync();

        // Early sop truncates the open frame
        send(mk(1'b1, 1'b0, 1'b0, 12'd8, 64'h81, 3'd0), 1'b1, xp(64'h81, 1'b1, 1'b0, 3'd0, 1'b0));
        send(mk(1'b0, 1'b0, 1'b0, 12'd8, 64'h82, 3'd0), 1'b1, xp(64'h82, 1'b0, 1'b0, 3'd0, 1'b0));
        send(mk(1'b1, 1'b0, 1'b0, 12'd9, 64'h91, 3'd0), 1'b1, xp(64'h91, 1'b0, 1'b1, 3'd0, 1'b1));
        send(mk(1'b0, 1'b0, 1'b0, 12'd9, 64'h92, 3'd0), 1'b0, '0);
        send(mk(1'b0, 1'b1, 1'b0, 12'd9, 64'h93, 3'd2), 1'b0, '0);
        drain();
        cnts("trunc", 4'd8, 4'd2, 12'd8);
        sync();

        // Mid-frame error carried to eop
        frame(12'd10, 4, 2);
        drain();
        cnts("err", 4'd9, 4'd2, 12'd10);
        sync();

        // Reset with the MAC stalled and two beats buffered
        mac_tx_ready = 1'b0;
        send(mk(1'b1, 1'b0, 1'b0, 12'd11, 64'hB1, 3'd0), 1'b1, '0);
        send(mk(1'b0, 1'b0, 1'b0, 12'd11, 64'hB2, 3'd0), 1'b1, '0);
        rst = 1'b1;
        q.delete();
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(mac_tx.valid), 64'd0);
        cnts("midrst", 4'd0, 4'd0, 12'h000);
        mac_tx_ready = 1'b1;
        sync();
        frame(12'd12, 2, 0);
        drain();
        cnts("after_rst", 4'd1, 4'd0, 12'd12);
        sync();

        // Counter wrap
        for (int i = 0; i < 14; i++) begin
            frame(12'(13 + i), 1, 0);
        end
        drain();
        cnts("pre_wrap", 4'd15, 4'd0, 12'd26);
        sync();
        frame(12'd27, 1, 0);
        drain();
        cnts("wrap", 4'd0, 4'd0, 12'd27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
